// File: rtl/cache_mem_bridge.sv
// Bridges the cache refill/writeback port onto the word-wide SRAM-like memory bus,
// splitting line transactions into single-word requests behind a one-line write buffer.
module cache_mem_bridge #(
  parameter int BYTES_PER_LINE  = 16,
  parameter int WORDS_PER_LINE  = BYTES_PER_LINE / 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rd_req,
  input  logic [31:0]                 rd_addr,
  input  logic [1:0]                  rd_size,
  input  logic                        rd_burst,
  output logic                        rd_rdy,
  output logic                        ret_valid,
  output logic                        ret_last,
  output logic [31:0]                 ret_data,
  input  logic                        wr_req,
  input  logic [31:0]                 wr_addr,
  input  logic [3:0]                  wr_strb,
  input  logic [1:0]                  wr_size,
  input  logic                        wr_burst,
  input  logic [BYTES_PER_LINE*8-1:0] wr_data,
  output logic                        wr_rdy,
  output logic                        mem_req,
  output logic                        mem_wr,
  output logic [1:0]                  mem_size,
  output logic [31:0]                 mem_addr,
  output logic [3:0]                  mem_wstrb,
  output logic [31:0]                 mem_wdata,
  input  logic                        mem_addr_ok,
  input  logic                        mem_data_ok,
  input  logic [31:0]                 mem_rdata
);

  localparam int IW  = $clog2(WORDS_PER_LINE);
  localparam int CW  = IW + 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int OFF = IW + 2;
  localparam logic [CW-1:0] LINE_CNT = CW'(WORDS_PER_LINE);
  localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {BUS_IDLE, BUS_READ, BUS_WRITE} bus_state_t;

  bus_state_t state, next_state;

  logic                        wr_full;
  logic [31:0]                 wa_q;
  logic [3:0]                  ws_q;
  logic [1:0]                  wsz_q;
  logic                        wb_q;
  logic [BYTES_PER_LINE*8-1:0] wd_q;
  logic [31:0]                 ra_q;
  logic [1:0]                  rsz_q;
  logic                        rb_q;

  logic [CW-1:0] issue_cnt, ack_cnt, total;
  logic [OW-1:0] outstanding;
  logic [IW-1:0] word_idx;
  logic          rd_accept, wr_accept, active_burst, issue, ack, last_ack;

  assign rd_rdy       = ~reset & (state == BUS_IDLE) & ~wr_full & ~wr_req;
  assign wr_rdy       = ~wr_full;
  assign rd_accept    = rd_req & rd_rdy;
  assign wr_accept    = wr_req & ~wr_full;
  assign active_burst = (state == BUS_WRITE) ? wb_q : rb_q;
  assign total        = active_burst ? LINE_CNT : CW'(1);
  assign word_idx     = issue_cnt[IW-1:0];
  assign mem_req      = (state != BUS_IDLE) & (issue_cnt != total) & (outstanding != OUT_MAX);
  assign issue        = mem_req & mem_addr_ok;
  // A response with nothing in flight is not ours to count.
  assign ack          = mem_data_ok & (outstanding != '0) & (state != BUS_IDLE);
  assign last_ack     = ack & (ack_cnt == total - CW'(1));
  assign ret_valid    = (state == BUS_READ) & ack;
  assign ret_last     = ret_valid & last_ack;
  assign ret_data     = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) state <= BUS_IDLE;
    else       state <= next_state;
  end

  // Reads only start with an empty buffer; a write caught behind a read waits in the buffer.
  always_comb begin
    next_state = state;
    case (state)
      BUS_IDLE: begin
        if (rd_accept)                 next_state = BUS_READ;
        else if (wr_full || wr_accept) next_state = BUS_WRITE;
      end
      BUS_READ:  if (last_ack) next_state = BUS_IDLE;
      BUS_WRITE: if (last_ack) next_state = BUS_IDLE;
      default:   next_state = BUS_IDLE;
    endcase
  end

  always_comb begin
    mem_wr    = 1'b0;
    mem_addr  = ra_q;
    mem_size  = rsz_q;
    mem_wstrb = 4'b0000;
    mem_wdata = 32'h0;
    if (state == BUS_WRITE) begin
      mem_wr    = 1'b1;
      mem_addr  = wb_q ? {wa_q[31:OFF], word_idx, 2'b00} : wa_q;
      mem_size  = wb_q ? 2'b10 : wsz_q;
      mem_wstrb = wb_q ? 4'b1111 : ws_q;
      mem_wdata = wb_q ? wd_q[{word_idx, 5'b00000} +: 32] : wd_q[31:0];
    end else if (rb_q) begin
      mem_addr  = {ra_q[31:OFF], word_idx, 2'b00};
      mem_size  = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt   <= '0;
      ack_cnt     <= '0;
      outstanding <= '0;
    end else if (last_ack) begin
      issue_cnt   <= '0;
      ack_cnt     <= '0;
      outstanding <= '0;
    end else begin
      if (issue) issue_cnt <= issue_cnt + CW'(1);
      if (ack)   ack_cnt   <= ack_cnt + CW'(1);
      if (issue && !ack)      outstanding <= outstanding + OW'(1);
      else if (!issue && ack) outstanding <= outstanding - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                wr_full <= 1'b0;
    else if (wr_accept)                       wr_full <= 1'b1;
    else if (state == BUS_WRITE && last_ack)  wr_full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      wa_q  <= wr_addr;
      ws_q  <= wr_strb;
      wsz_q <= wr_size;
      wb_q  <= wr_burst;
      wd_q  <= wr_data;
    end
    if (rd_accept) begin
      ra_q  <= rd_addr;
      rsz_q <= rd_size;
      rb_q  <= rd_burst;
    end
  end

endmodule

// File: doc/cache_mem_bridge.md
Name: cache_mem_bridge

Overview:
- Responder for the cache's refill/writeback port: rd_req/rd_rdy/ret_*, plus wr_req/wr_rdy with a full-line wr_data.
- Converts each cache transaction into a sequence of single-word requests on the word-wide SRAM-like memory bus (req/addr_ok/data_ok).
- Sits between each cache instance (I$ and D$) and the memory-side arbiter.
- Holds one write line in a writeback buffer and orders reads behind it.

Parameters:
- BYTES_PER_LINE, 16, cache line size in bytes; must match the attached cache.
- WORDS_PER_LINE, BYTES_PER_LINE/4, words per burst.
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered memory requests (power of 2, ≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rd_req  in  1  cache read request
- rd_addr  in  32  read address; line-aligned when burst=1
- rd_size  in  2  access size for uncached read
- rd_burst  in  1  1 = full line, 0 = single uncached word (tied to cache burst)
- rd_rdy  out  1  read request accepted when rd_req&rd_rdy
- ret_valid  out  1  one returned word this cycle
- ret_last  out  1  final word of current read
- ret_data  out  32  returned word
- wr_req  in  1  cache write request
- wr_addr  in  32  write address
- wr_strb  in  4  byte enables, used for uncached only
- wr_size  in  2  access size for uncached write
- wr_burst  in  1  1 = full-line writeback, 0 = single uncached word
- wr_data  in  BYTES_PER_LINE*8  line data; word 0 in bits [31:0]
- wr_rdy  out  1  write buffer empty
- mem_req  out  1  memory request valid
- mem_wr  out  1  1 = write
- mem_size  out  2  access size
- mem_addr  out  32  word address
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  write data
- mem_addr_ok  in  1  request accepted when mem_req&mem_addr_ok
- mem_data_ok  in  1  one response (read data or write ack), in order
- mem_rdata  in  32  read data

Behaviour:
- Reset values: rd_rdy=0 during reset and 1 the cycle after; wr_rdy=1; ret_valid=0; ret_last=0; mem_req=0; all counters 0. Reset mid-transaction discards all state; the memory side is reset by the same signal.
- Write engine:
  - Write accept: wr_req&wr_rdy latches addr/strb/size/burst/data into the line buffer. wr_rdy falls the next cycle and rises the cycle after the final write ack.
  - wr_rdy is a level, not a pulse: it stays 1 while the buffer is empty, even if wr_req arrives several cycles after wr_rdy was sampled.
  - Cached write (burst=1): issue WORDS_PER_LINE writes.
    - mem_addr = {line addr, word idx, 2'b00}; idx counts 0..WORDS_PER_LINE-1.
    - mem_wstrb = 4'b1111; mem_size = 2'b10; mem_wdata = word idx of buffer.
  - Uncached write (burst=0): one write with latched addr, wr_strb, wr_size, and data word 0.
- Read engine:
  - rd_rdy = read idle & write buffer empty & ~wr_req. A read never overtakes a pending writeback; a same-cycle rd_req+wr_req takes the write.
  - Read accept: latch rd_addr/size/burst. Issue count = WORDS_PER_LINE if burst, else 1.
  - Cached read: size 2'b10, addresses incrementing by 4 from the line base. Uncached read: latched rd_size, exact address.
- Issue/ack counters:
  - issue_cnt advances on mem_req&mem_addr_ok. mem_req deasserts when issue_cnt == total or outstanding == MAX_OUTSTANDING.
  - outstanding +1 on issue, −1 on data_ok; simultaneous issue and data_ok leaves it unchanged.
  - mem_req/mem_addr/mem_wr stay stable until mem_addr_ok.
- Read return:
  - Each mem_data_ok during a read gives ret_valid=1 with ret_data = mem_rdata in the same cycle (combinational, zero added latency).
  - ret_last=1 on the final word. The read returns to idle the next cycle; rd_rdy may be 1 that cycle.
- Ack counter is $clog2(WORDS_PER_LINE)+1 bits and does not wrap within a transaction.
- Only one of the read/write engines drives the memory bus at a time. mem_wr reflects the active engine.
- mem_data_ok arriving with no outstanding request is ignored. The bench flags it as an error.

Test Plan:
- Cached read, rd_addr=0x1000_0040, mem_addr_ok always 1, data_ok 1 cycle after issue -> mem_addr 0x...40,44,48,4C; 4 ret_valid; ret_last only on the 4th; rd_rdy high again right after.
- Uncached read, rd_burst=0, rd_addr=0xBFC0_0004, rd_size=1 -> exactly one mem_req with size 1, addr 0xBFC0_0004; ret_valid&ret_last together.
- Writeback: wr_data words {A,B,C,D}, wr_addr=0x200, then rd_req the same cycle -> writes 0x200..0x20C with data A..D and strb F. rd_rdy stays 0 until the 4th ack; only then is the read issued.
- Uncached write, wr_strb=4'b0011, wr_size=1 -> single mem write with strb 0011. wr_rdy falls for the transaction and rises the cycle after the ack.
- Backpressure: mem_addr_ok low 3 cycles and random data_ok delays -> outstanding never exceeds MAX_OUTSTANDING; addr/data stay stable while stalled; returned order is preserved.
- Reset asserted mid-burst after 2 of 4 words -> next cycle: rd_rdy=1, wr_rdy=1, mem_req=0, no further ret_valid.
